sensor_timing_gen: RTL and testbench

Run-time-programmable image-sensor timing generator. Produces HD/VD line- and frame-valid strobes plus pixel/line counters from a single pixel clock (CLI domain).
Replaces fixed-geometry timing with programmable total/active windows and free-run, single-frame and burst modes. Config is shadow-latched at frame boundaries, so it can change during a run without glitching.

---
 rtl/sensor_timing_gen_pkg.sv | 25 ++
 rtl/sensor_timing_gen_if.sv | 22 ++
 rtl/timing_window_cmp.sv | 18 +
 rtl/sensor_timing_gen.sv | 101 ++++++++++
 tb/tb_sensor_timing_gen.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/sensor_timing_gen_pkg.sv
// sensor_timing_pkg: shared widths, mode/state enums, geometry shadow struct and config validity check
package sensor_timing_pkg;
  localparam int H_W = 16;
  localparam int V_W = 13;
  localparam int F_W = 8;
  typedef enum logic [1:0] {FREE = 2'b00, SINGLE = 2'b01, BURST = 2'b10, RSVD = 2'b11} mode_e;
  typedef enum logic [1:0] {IDLE, RUN, STOP_PEND} state_e;
  typedef struct packed {
    logic [H_W-1:0] h_total;
    logic [H_W-1:0] h_act_s;
    logic [H_W-1:0] h_act_e;
    logic [V_W-1:0] v_total;
    logic [V_W-1:0] v_act_s;
    logic [V_W-1:0] v_act_e;
    logic [F_W-1:0] n_frames;
  } timing_cfg_t;
  // act_e may equal total+1, so the upper bound is checked one bit wider
  function automatic logic cfg_valid(timing_cfg_t c, mode_e m);
    return c.h_total != '0 && c.h_act_s < c.h_act_e &&
           {1'b0, c.h_act_e} <= {1'b0, c.h_total} + (H_W+1)'(1) &&
           c.v_act_s < c.v_act_e &&
           {1'b0, c.v_act_e} <= {1'b0, c.v_total} + (V_W+1)'(1) &&
           m != RSVD;
  endfunction
endpackage

// File: rtl/sensor_timing_gen_if.sv
// sensor_timing_gen_if: control, geometry config and timing outputs of the sensor timing generator
interface sensor_timing_gen_if;
  import sensor_timing_pkg::*;
  logic start;
  logic stop;
  logic abort;
  logic [1:0] mode;
  timing_cfg_t cfg;
  logic [H_W-1:0] hcnt;
  logic [V_W-1:0] vcnt;
  logic [F_W-1:0] fcnt;
  logic HD;
  logic VD;
  logic frame_start;
  logic frame_done;
  logic busy;
  logic cfg_err;
  modport master(output start, stop, abort, mode, cfg,
                 input hcnt, vcnt, fcnt, HD, VD, frame_start, frame_done, busy, cfg_err);
  modport slave(input start, stop, abort, mode, cfg,
                output hcnt, vcnt, fcnt, HD, VD, frame_start, frame_done, busy, cfg_err);
endinterface

// File: rtl/timing_window_cmp.sv
// timing_window_cmp: registered "count inside [s,e)" flag, gated by en
module timing_window_cmp #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] cnt,
  input  logic [W-1:0] s,
  input  logic [W-1:0] e,
  output logic         valid_q
);
  logic valid_d;
  always_comb valid_d = en && {1'b0, cnt} >= {1'b0, s} && {1'b0, cnt} < {1'b0, e};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) valid_q <= 1'b0;
    else valid_q <= valid_d;
endmodule

// File: rtl/sensor_timing_gen.sv
// sensor_timing_gen: programmable HD/VD timing generator with shadowed geometry and free/single/burst runs
module sensor_timing_gen
  import sensor_timing_pkg::*;
(
  input logic clk,
  input logic rst_n,
  sensor_timing_gen_if.slave sif
);
  state_e state_q, state_d;
  mode_e mode_q, mode_d, mode_in;
  timing_cfg_t sh_q, sh_d;
  logic [H_W-1:0] hcnt_q, hcnt_d;
  logic [V_W-1:0] vcnt_q, vcnt_d;
  logic [F_W-1:0] fcnt_q, fcnt_d, nf;
  logic fs_q, fs_d, fd_q, fd_d, err_q, err_d;
  logic ok, h_wrap, eof, term, run_d, h_in, v_in;
  assign mode_in = mode_e'(sif.mode);
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    sh_d = sh_q;
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    fcnt_d = fcnt_q;
    err_d = err_q;
    ok = cfg_valid(sif.cfg, mode_in);
    nf = sh_q.n_frames == '0 ? F_W'(1) : sh_q.n_frames;
    h_wrap = hcnt_q == sh_q.h_total;
    eof = h_wrap && vcnt_q == sh_q.v_total;
    term = state_q == STOP_PEND || sif.stop || mode_q == SINGLE ||
           (mode_q == BURST && {1'b0, fcnt_q} + (F_W+1)'(1) == {1'b0, nf});
    if (sif.abort) begin
      state_d = IDLE;
      hcnt_d = '0;
      vcnt_d = '0;
    end else if (state_q == IDLE) begin
      if (sif.start && ok) begin
        state_d = RUN;
        sh_d = sif.cfg;
        mode_d = mode_in;
        fcnt_d = '0;
        err_d = 1'b0;
      end else if (sif.start) err_d = 1'b1;
    end else begin
      hcnt_d = h_wrap ? '0 : hcnt_q + H_W'(1);
      vcnt_d = eof ? '0 : h_wrap ? vcnt_q + V_W'(1) : vcnt_q;
      if (state_q == RUN && sif.stop) state_d = STOP_PEND;
      if (eof) begin
        fcnt_d = &fcnt_q ? fcnt_q : fcnt_q + F_W'(1);
        if (term) state_d = IDLE;
        else if (ok) begin
          sh_d = sif.cfg;
          mode_d = mode_in;
        end else err_d = 1'b1;
      end
    end
    run_d = state_d != IDLE;
    fs_d = run_d && hcnt_d == '0 && vcnt_d == '0;
    fd_d = run_d && hcnt_d == sh_d.h_total && vcnt_d == sh_d.v_total;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q <= FREE;
      sh_q <= '0;
      hcnt_q <= '0;
      vcnt_q <= '0;
      fcnt_q <= '0;
      fs_q <= 1'b0;
      fd_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      sh_q <= sh_d;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      fcnt_q <= fcnt_d;
      fs_q <= fs_d;
      fd_q <= fd_d;
      err_q <= err_d;
    end
  // windows see next-cycle counts so HD/VD line up with hcnt/vcnt
  timing_window_cmp #(.W(H_W)) u_h_win (
    .clk(clk), .rst_n(rst_n), .en(run_d), .cnt(hcnt_d),
    .s(sh_d.h_act_s), .e(sh_d.h_act_e), .valid_q(h_in)
  );
  timing_window_cmp #(.W(V_W)) u_v_win (
    .clk(clk), .rst_n(rst_n), .en(run_d), .cnt(vcnt_d),
    .s(sh_d.v_act_s), .e(sh_d.v_act_e), .valid_q(v_in)
  );
  assign sif.hcnt = hcnt_q;
  assign sif.vcnt = vcnt_q;
  assign sif.fcnt = fcnt_q;
  assign sif.HD = h_in & v_in;
  assign sif.VD = v_in;
  assign sif.frame_start = fs_q;
  assign sif.frame_done = fd_q;
  assign sif.busy = state_q != IDLE;
  assign sif.cfg_err = err_q;
endmodule

// File: tb/tb_sensor_timing_gen.sv
// tb_sensor_timing_gen: vector table for first-frame timing, frame_done scoreboard, corner-case sequences
module tb_sensor_timing_gen;
  import sensor_timing_pkg::*;
  typedef struct {
    int off;
    int h;
    int v;
    int hd;
    int vd;
    int fs;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int t0 = 0;
  int exp_q[$];
  vec_t vecs[9];
  sensor_timing_gen_if sif();
  sensor_timing_gen dut (.clk(clk), .rst_n(rst_n), .sif(sif));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string n, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  task automatic step();
    int e;
    @(negedge clk);
    if (sif.frame_done === 1'b1) begin
      e = -1;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      chk("frame_done_cycle", cyc, e);
      chk("frame_done_pos", int'(sif.hcnt), int'(dut.sh_q.h_total));
    end
  endtask
  task automatic go(int off);
    while (cyc - t0 < off) step();
  endtask
  task automatic set_geo(int ht, int hs, int he, int vt, int vs, int ve);
    sif.cfg.h_total = H_W'(ht);
    sif.cfg.h_act_s = H_W'(hs);
    sif.cfg.h_act_e = H_W'(he);
    sif.cfg.v_total = V_W'(vt);
    sif.cfg.v_act_s = V_W'(vs);
    sif.cfg.v_act_e = V_W'(ve);
  endtask
  task automatic start_run(logic [1:0] m);
    sif.mode = m;
    sif.start = 1'b1;
    step();
    sif.start = 1'b0;
    t0 = cyc;
  endtask
  task automatic idle_chk(string n, int f);
    chk({n, "_busy"}, int'(sif.busy), 0);
    chk({n, "_hcnt"}, int'(sif.hcnt), 0);
    chk({n, "_vcnt"}, int'(sif.vcnt), 0);
    chk({n, "_hdvd"}, int'({sif.HD, sif.VD}), 0);
    chk({n, "_fcnt"}, int'(sif.fcnt), f);
    chk({n, "_pending_fd"}, exp_q.size(), 0);
  endtask
  initial begin
    vecs[0] = '{0, 0, 0, 0, 0, 1};
    vecs[1] = '{6, 6, 0, 0, 0, 0};
    vecs[2] = '{7, 7, 0, 0, 0, 0};
    vecs[3] = '{70, 6, 1, 0, 1, 0};
    vecs[4] = '{71, 7, 1, 1, 1, 0};
    vecs[5] = '{127, 63, 1, 1, 1, 0};
    vecs[6] = '{128, 0, 2, 0, 1, 0};
    vecs[7] = '{2047, 63, 31, 1, 1, 0};
    vecs[8] = '{2048, 0, 0, 0, 0, 1};
    sif.start = 1'b0;
    sif.stop = 1'b0;
    sif.abort = 1'b0;
    sif.mode = 2'b00;
    sif.cfg.n_frames = '0;
    set_geo(63, 7, 64, 31, 1, 32);
    #1;
    chk("reset_outs", int'({sif.hcnt, sif.vcnt}), 0);
    chk("reset_flags", int'({sif.fcnt, sif.HD, sif.VD, sif.frame_start, sif.frame_done, sif.busy, sif.cfg_err}), 0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    // FREE run: table over the first frame, then a graceful stop mid frame 2
    start_run(2'b00);
    exp_q.push_back(t0 + 2047);
    exp_q.push_back(t0 + 4095);
    for (int i = 0; i < 9; i++) begin
      go(vecs[i].off);
      chk($sformatf("vec%0d_hcnt", i), int'(sif.hcnt), vecs[i].h);
      chk($sformatf("vec%0d_vcnt", i), int'(sif.vcnt), vecs[i].v);
      chk($sformatf("vec%0d_HD", i), int'(sif.HD), vecs[i].hd);
      chk($sformatf("vec%0d_VD", i), int'(sif.VD), vecs[i].vd);
      chk($sformatf("vec%0d_fs", i), int'(sif.frame_start), vecs[i].fs);
    end
    go(2048 + 5 * 64 + 10);
    sif.stop = 1'b1;
    step();
    sif.stop = 1'b0;
    go(4095);
    chk("stop_busy_at_eof", int'(sif.busy), 1);
    chk("stop_eof_pos", int'({sif.hcnt, 3'b0, sif.vcnt}), int'({16'd63, 16'd31}));
    step();
    idle_chk("stop_idle", 2);
    // SINGLE
    start_run(2'b01);
    exp_q.push_back(t0 + 2047);
    go(2047);
    chk("single_busy_eof", int'(sif.busy), 1);
    step();
    idle_chk("single_idle", 1);
    repeat (5) step();
    // BURST 3 then BURST 0 (treated as 1)
    sif.cfg.n_frames = 8'd3;
    start_run(2'b10);
    for (int k = 1; k <= 3; k++) exp_q.push_back(t0 + k * 2048 - 1);
    go(3 * 2048 - 1);
    chk("burst3_busy_last", int'(sif.busy), 1);
    step();
    idle_chk("burst3_idle", 3);
    sif.cfg.n_frames = 8'd0;
    start_run(2'b10);
    exp_q.push_back(t0 + 2047);
    go(2048);
    idle_chk("burst0_idle", 1);
    // stop asserted on the EOF cycle itself
    start_run(2'b00);
    exp_q.push_back(t0 + 2047);
    go(2047);
    sif.stop = 1'b1;
    step();
    sif.stop = 1'b0;
    idle_chk("stop_eof_idle", 1);
    // invalid config at start
    set_geo(63, 20, 20, 31, 1, 32);
    sif.start = 1'b1;
    step();
    sif.start = 1'b0;
    chk("inv_cfg_err", int'(sif.cfg_err), 1);
    chk("inv_busy", int'(sif.busy), 0);
    repeat (3) step();
    chk("inv_busy_later", int'(sif.busy), 0);
    // mid-run geometry change, then invalid mid-run change, then abort
    set_geo(63, 7, 64, 31, 1, 32);
    start_run(2'b00);
    chk("mid_err_cleared", int'(sif.cfg_err), 0);
    exp_q.push_back(t0 + 2047);
    exp_q.push_back(t0 + 3071);
    go(100);
    set_geo(31, 7, 32, 31, 1, 32);
    go(2047);
    chk("mid_old_htotal", int'(sif.hcnt), 63);
    go(2048 + 31);
    chk("mid_new_hlast", int'(sif.hcnt), 31);
    step();
    chk("mid_new_wrap_h", int'(sif.hcnt), 0);
    chk("mid_new_wrap_v", int'(sif.vcnt), 1);
    go(2048 + 100);
    set_geo(31, 20, 20, 31, 1, 32);
    go(3071);
    chk("mid_err_before_eof", int'(sif.cfg_err), 0);
    step();
    chk("mid_err_after_eof", int'(sif.cfg_err), 1);
    go(3072 + 31);
    chk("mid_kept_hlast", int'(sif.hcnt), 31);
    step();
    chk("mid_kept_wrap_v", int'(sif.vcnt), 1);
    go(3072 + 40);
    chk("abort_pre_HD", int'(sif.HD), 1);
    sif.abort = 1'b1;
    step();
    sif.abort = 1'b0;
    idle_chk("abort_idle", 2);
    repeat (4) step();
    chk("abort_busy_later", int'(sif.busy), 0);
    // asynchronous reset mid-frame
    set_geo(63, 7, 64, 31, 1, 32);
    start_run(2'b00);
    chk("ar_err_cleared", int'(sif.cfg_err), 0);
    go(300);
    chk("ar_pre_HD", int'(sif.HD), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_outs", int'({sif.hcnt, sif.vcnt}), 0);
    chk("ar_flags", int'({sif.fcnt, sif.HD, sif.VD, sif.frame_start, sif.frame_done, sif.busy, sif.cfg_err}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();
    idle_chk("ar_idle", 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
